// File: rtl/rm_mailbox_pkg.sv
// Shared constants for the host/core mailbox: register offsets on both
// ports, interrupt pending bit positions and the STATUS word layout.
package rm_mailbox_pkg;

  // Host-side Wishbone word offsets
  localparam logic [3:0] HOST_IRQ_PEND = 4'd0;
  localparam logic [3:0] HOST_IRQ_EN   = 4'd1;
  localparam logic [3:0] HOST_STATUS   = 4'd2;
  localparam logic [3:0] HOST_H2C_DATA = 4'd3;
  localparam logic [3:0] HOST_C2H_DATA = 4'd4;
  localparam logic [3:0] HOST_CTRL     = 4'd5;

  // Core-side IO offsets
  localparam logic [1:0] CORE_H2C_DATA = 2'd0;
  localparam logic [1:0] CORE_C2H_DATA = 2'd1;
  localparam logic [1:0] CORE_STATUS   = 2'd2;
  localparam logic [1:0] CORE_PEND     = 2'd3;

  // Host IRQ_PEND bit indices
  localparam int IRQ_H_C2H_NOT_EMPTY = 0;
  localparam int IRQ_H_H2C_NOT_FULL  = 1;
  localparam int IRQ_H_H2C_OVERFLOW  = 2;
  localparam int IRQ_H_C2H_UNDERFLOW = 3;

  // Core CORE_PEND bit indices (directions swapped relative to host)
  localparam int IRQ_C_H2C_NOT_EMPTY = 0;
  localparam int IRQ_C_C2H_NOT_FULL  = 1;
  localparam int IRQ_C_C2H_OVERFLOW  = 2;
  localparam int IRQ_C_H2C_UNDERFLOW = 3;

  // STATUS field positions
  localparam int STATUS_H2C_LSB = 0;
  localparam int STATUS_C2H_LSB = 16;

  // CTRL flush bits
  localparam int CTRL_FLUSH_H2C = 0;
  localparam int CTRL_FLUSH_C2H = 1;

  // Index of each FIFO in the instance array
  localparam int FIFO_H2C = 0;
  localparam int FIFO_C2H = 1;

  // Pack both FIFO counts into the STATUS word shared by host and core
  function automatic logic [31:0] status_word(input logic [15:0] h2c_count,
                                              input logic [15:0] c2h_count);
    return (32'(c2h_count) << STATUS_C2H_LSB) | (32'(h2c_count) << STATUS_H2C_LSB);
  endfunction

endpackage

// File: rtl/mbox_fifo.sv
// Synchronous FIFO used for each mailbox direction. Read data is registered
// (one cycle after pop). A pop on empty yields zero, a push on full is
// dropped even if a pop happens the same cycle, and flush overrides both.
module mbox_fifo #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 16,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = dout_q;

  // Next-state for pointers, occupancy and read register
  always_comb begin
    do_push  = push && !full && !flush;
    do_pop   = pop && !empty && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      dout_d   = '0;
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        dout_d   = mem[rd_ptr_q];
      end else if (pop) begin
        dout_d = '0;
      end
      if (do_push && !do_pop) begin
        count_d = count_q + CW'(1);
      end else if (!do_push && do_pop) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  // Storage write; contents deliberately survive reset
  always_ff @(posedge sys_clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= din;
    end
  end

  // Control and read-data registers
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end

endmodule

// File: rtl/rm_mailbox.sv
// Host/core mailbox: a pipelined Wishbone slave on the host side and a simple
// IO port on the core side, joined by an H2C and a C2H FIFO with per-side
// pending bits and interrupts.
module rm_mailbox
  import rm_mailbox_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 16,
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic [3:0]  wbs_adr,
  input  logic [31:0] wbs_dat_w,
  output logic [31:0] wbs_dat_r,
  input  logic [3:0]  wbs_sel,
  input  logic        wbs_cyc,
  input  logic        wbs_stb,
  input  logic        wbs_we,
  output logic        wbs_ack,
  output logic        wbs_stall,
  output logic        wbs_err,
  input  logic [1:0]  io_addr,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [31:0] io_dout,
  output logic [31:0] io_din,
  output logic        irq_host,
  output logic        irq_core
);

  logic                   host_rd, host_wr;
  logic [1:0]             fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [1:0][DATA_W-1:0] fifo_din, fifo_dout;
  logic [1:0][CW-1:0]     fifo_count;
  logic [31:0]            status;

  logic [3:0]  host_pend, core_pend, host_w1c, core_w1c;
  logic [3:0]  irq_en_q, irq_en_d;
  logic        h_ovf_q, h_ovf_d, h_unf_q, h_unf_d;
  logic        c_ovf_q, c_ovf_d, c_unf_q, c_unf_d;
  logic        irq_host_q, irq_host_d, irq_core_q, irq_core_d;
  logic        ack_q, ack_d;
  logic        host_sel_fifo_q, host_sel_fifo_d;
  logic        core_sel_fifo_q, core_sel_fifo_d;
  logic [31:0] host_rdat_q, host_rdat_d;
  logic [31:0] core_rdat_q, core_rdat_d;
  logic        unused_inputs;

  // Decode host strobes and core accesses into FIFO controls
  always_comb begin
    host_rd    = wbs_cyc && wbs_stb && !wbs_we;
    host_wr    = wbs_cyc && wbs_stb && wbs_we;
    fifo_push  = '0;
    fifo_pop   = '0;
    fifo_flush = '0;
    fifo_push[FIFO_H2C]  = host_wr && (wbs_adr == HOST_H2C_DATA);
    fifo_pop[FIFO_H2C]   = io_rd && (io_addr == CORE_H2C_DATA);
    fifo_flush[FIFO_H2C] = host_wr && (wbs_adr == HOST_CTRL) && wbs_dat_w[CTRL_FLUSH_H2C];
    fifo_push[FIFO_C2H]  = io_wr && (io_addr == CORE_C2H_DATA);
    fifo_pop[FIFO_C2H]   = host_rd && (wbs_adr == HOST_C2H_DATA);
    fifo_flush[FIFO_C2H] = host_wr && (wbs_adr == HOST_CTRL) && wbs_dat_w[CTRL_FLUSH_C2H];
    fifo_din[FIFO_H2C]   = wbs_dat_w[DATA_W-1:0];
    fifo_din[FIFO_C2H]   = io_dout[DATA_W-1:0];
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      mbox_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
      ) u_fifo (
        .sys_clk (sys_clk),
        .rst     (rst),
        .push    (fifo_push[gi]),
        .pop     (fifo_pop[gi]),
        .flush   (fifo_flush[gi]),
        .din     (fifo_din[gi]),
        .dout    (fifo_dout[gi]),
        .count   (fifo_count[gi]),
        .full    (fifo_full[gi]),
        .empty   (fifo_empty[gi])
      );
    end
  endgenerate

  assign status = status_word(16'(fifo_count[FIFO_H2C]), 16'(fifo_count[FIFO_C2H]));

  // Pending bits: level bits follow FIFO state, sticky bits set wins over W1C
  always_comb begin
    host_pend = '0;
    host_pend[IRQ_H_C2H_NOT_EMPTY] = !fifo_empty[FIFO_C2H];
    host_pend[IRQ_H_H2C_NOT_FULL]  = !fifo_full[FIFO_H2C];
    host_pend[IRQ_H_H2C_OVERFLOW]  = h_ovf_q;
    host_pend[IRQ_H_C2H_UNDERFLOW] = h_unf_q;
    core_pend = '0;
    core_pend[IRQ_C_H2C_NOT_EMPTY] = !fifo_empty[FIFO_H2C];
    core_pend[IRQ_C_C2H_NOT_FULL]  = !fifo_full[FIFO_C2H];
    core_pend[IRQ_C_C2H_OVERFLOW]  = c_ovf_q;
    core_pend[IRQ_C_H2C_UNDERFLOW] = c_unf_q;
    host_w1c = (host_wr && (wbs_adr == HOST_IRQ_PEND)) ? wbs_dat_w[3:0] : 4'h0;
    core_w1c = (io_wr && (io_addr == CORE_PEND)) ? io_dout[3:0] : 4'h0;
    h_ovf_d = (h_ovf_q && !host_w1c[IRQ_H_H2C_OVERFLOW])
              || (fifo_push[FIFO_H2C] && fifo_full[FIFO_H2C]);
    h_unf_d = (h_unf_q && !host_w1c[IRQ_H_C2H_UNDERFLOW])
              || (fifo_pop[FIFO_C2H] && fifo_empty[FIFO_C2H]);
    c_ovf_d = (c_ovf_q && !core_w1c[IRQ_C_C2H_OVERFLOW])
              || (fifo_push[FIFO_C2H] && fifo_full[FIFO_C2H]);
    c_unf_d = (c_unf_q && !core_w1c[IRQ_C_H2C_UNDERFLOW])
              || (fifo_pop[FIFO_H2C] && fifo_empty[FIFO_H2C]);
    irq_en_d   = (host_wr && (wbs_adr == HOST_IRQ_EN)) ? wbs_dat_w[3:0] : irq_en_q;
    irq_host_d = |(host_pend & irq_en_q);
    irq_core_d = core_pend[IRQ_C_H2C_NOT_EMPTY];
  end

  // Read-data capture for both ports; FIFO pops are selected from the FIFO read register
  always_comb begin
    ack_d           = wbs_cyc && wbs_stb;
    host_sel_fifo_d = fifo_pop[FIFO_C2H];
    host_rdat_d     = '0;
    if (host_rd) begin
      case (wbs_adr)
        HOST_IRQ_PEND: host_rdat_d = 32'(host_pend);
        HOST_IRQ_EN:   host_rdat_d = 32'(irq_en_q);
        HOST_STATUS:   host_rdat_d = status;
        default:       host_rdat_d = '0;
      endcase
    end
    core_sel_fifo_d = fifo_pop[FIFO_H2C];
    core_rdat_d     = '0;
    if (io_rd) begin
      case (io_addr)
        CORE_STATUS: core_rdat_d = status;
        CORE_PEND:   core_rdat_d = 32'(core_pend);
        default:     core_rdat_d = '0;
      endcase
    end
  end

  // Register state; reset also drops any ack owed to an in-flight strobe
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      irq_en_q        <= '0;
      h_ovf_q         <= 1'b0;
      h_unf_q         <= 1'b0;
      c_ovf_q         <= 1'b0;
      c_unf_q         <= 1'b0;
      irq_host_q      <= 1'b0;
      irq_core_q      <= 1'b0;
      ack_q           <= 1'b0;
      host_sel_fifo_q <= 1'b0;
      core_sel_fifo_q <= 1'b0;
      host_rdat_q     <= '0;
      core_rdat_q     <= '0;
    end else begin
      irq_en_q        <= irq_en_d;
      h_ovf_q         <= h_ovf_d;
      h_unf_q         <= h_unf_d;
      c_ovf_q         <= c_ovf_d;
      c_unf_q         <= c_unf_d;
      irq_host_q      <= irq_host_d;
      irq_core_q      <= irq_core_d;
      ack_q           <= ack_d;
      host_sel_fifo_q <= host_sel_fifo_d;
      core_sel_fifo_q <= core_sel_fifo_d;
      host_rdat_q     <= host_rdat_d;
      core_rdat_q     <= core_rdat_d;
    end
  end

  assign wbs_ack   = ack_q && wbs_cyc;
  assign wbs_stall = 1'b0;
  assign wbs_err   = 1'b0;
  assign wbs_dat_r = host_sel_fifo_q ? 32'(fifo_dout[FIFO_C2H]) : host_rdat_q;
  assign io_din    = core_sel_fifo_q ? 32'(fifo_dout[FIFO_H2C]) : core_rdat_q;
  assign irq_host  = irq_host_q;
  assign irq_core  = irq_core_q;

  // Byte selects are ignored and upper data bits are unused when DATA_W < 32
  assign unused_inputs = ^{wbs_sel, wbs_dat_w, io_dout};

endmodule

// File: tb/tb_rm_mailbox.sv
// Bench for rm_mailbox: directed scenarios plus biased random traffic, all
// checked against a queue-based transaction model of the mailbox.
module tb_rm_mailbox;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic [3:0]  wbs_adr;
  logic [31:0] wbs_dat_w;
  logic [31:0] wbs_dat_r;
  logic [3:0]  wbs_sel;
  logic        wbs_cyc, wbs_stb, wbs_we;
  logic        wbs_ack, wbs_stall, wbs_err;
  logic [1:0]  io_addr;
  logic        io_rd, io_wr;
  logic [31:0] io_dout;
  logic [31:0] io_din;
  logic        irq_host, irq_core;

  always #5 sys_clk = ~sys_clk;

  rm_mailbox #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .wbs_adr   (wbs_adr),
    .wbs_dat_w (wbs_dat_w),
    .wbs_dat_r (wbs_dat_r),
    .wbs_sel   (wbs_sel),
    .wbs_cyc   (wbs_cyc),
    .wbs_stb   (wbs_stb),
    .wbs_we    (wbs_we),
    .wbs_ack   (wbs_ack),
    .wbs_stall (wbs_stall),
    .wbs_err   (wbs_err),
    .io_addr   (io_addr),
    .io_rd     (io_rd),
    .io_wr     (io_wr),
    .io_dout   (io_dout),
    .io_din    (io_din),
    .irq_host  (irq_host),
    .irq_core  (irq_core)
  );

  int checks   = 0;
  int failures = 0;
  int txn      = 0;

  // Reference model state
  logic [31:0] h2c_m[$];
  logic [31:0] c2h_m[$];
  bit          h_ovf, h_unf, c_ovf, c_unf;
  logic [3:0]  en_m;
  logic [31:0] hv, cv, v;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // One clock of stimulus on both ports, model update, and response check
  task automatic cycle(input bit r, input bit stb, input bit we, input logic [3:0] adr,
                       input logic [31:0] wd, input bit rd, input bit wr, input logic [1:0] ia,
                       input logic [31:0] iw, output logic [31:0] hrd, output logic [31:0] crd);
    int          hn, cn;
    logic [3:0]  hp, cp, hw1c, cw1c;
    logic [31:0] st, e_dat, e_io;
    bit          e_ack, e_ih, e_ic, hw, hr, fl_h, fl_c;
    rst = r; wbs_cyc = stb; wbs_stb = stb; wbs_we = we; wbs_adr = adr; wbs_dat_w = wd;
    wbs_sel = 4'hf; io_rd = rd; io_wr = wr; io_addr = ia; io_dout = iw;

    hn = h2c_m.size();
    cn = c2h_m.size();
    hp = {h_unf, h_ovf, (hn < DEPTH), (cn > 0)};
    cp = {c_unf, c_ovf, (cn < DEPTH), (hn > 0)};
    st = (32'(cn) << 16) | 32'(hn);
    hw = stb && we;
    hr = stb && !we;
    fl_h = hw && adr == 4'd5 && wd[0];
    fl_c = hw && adr == 4'd5 && wd[1];
    hw1c = (hw && adr == 4'd0) ? wd[3:0] : 4'h0;
    cw1c = (wr && ia == 2'd3) ? iw[3:0] : 4'h0;
    e_ack = stb;
    e_ih = |(hp & en_m);
    e_ic = (hn > 0);
    e_dat = 0;
    if (hr) begin
      case (adr)
        4'd0: e_dat = 32'(hp);
        4'd1: e_dat = 32'(en_m);
        4'd2: e_dat = st;
        4'd4: e_dat = (cn > 0) ? c2h_m[0] : 32'h0;
        default: e_dat = 0;
      endcase
    end
    e_io = 0;
    if (rd) begin
      case (ia)
        2'd0: e_io = (hn > 0 && !fl_h) ? h2c_m[0] : 32'h0;
        2'd2: e_io = st;
        2'd3: e_io = 32'(cp);
        default: e_io = 0;
      endcase
    end

    if (r) begin
      h2c_m.delete(); c2h_m.delete();
      h_ovf = 0; h_unf = 0; c_ovf = 0; c_unf = 0; en_m = 0;
      e_ack = 0; e_dat = 0; e_io = 0; e_ih = 0; e_ic = 0;
    end else begin
      h_ovf = (h_ovf && !hw1c[2]) || (hw && adr == 4'd3 && hn == DEPTH);
      h_unf = (h_unf && !hw1c[3]) || (hr && adr == 4'd4 && cn == 0);
      c_ovf = (c_ovf && !cw1c[2]) || (wr && ia == 2'd1 && cn == DEPTH);
      c_unf = (c_unf && !cw1c[3]) || (rd && ia == 2'd0 && hn == 0);
      if (hw && adr == 4'd1) en_m = wd[3:0];
      if (fl_h) h2c_m.delete();
      else begin
        if (rd && ia == 2'd0 && hn > 0) void'(h2c_m.pop_front());
        if (hw && adr == 4'd3 && hn < DEPTH) h2c_m.push_back(wd);
      end
      if (fl_c) c2h_m.delete();
      else begin
        if (hr && adr == 4'd4 && cn > 0) void'(c2h_m.pop_front());
        if (wr && ia == 2'd1 && cn < DEPTH) c2h_m.push_back(iw);
      end
    end

    @(posedge sys_clk);
    #1;
    check_eq("wbs_ack", 32'(wbs_ack), 32'(e_ack));
    check_eq("stall_err", 32'({wbs_stall, wbs_err}), 32'h0);
    if (e_ack || r) check_eq("wbs_dat_r", wbs_dat_r, e_dat);
    if (rd || r) check_eq("io_din", io_din, e_io);
    check_eq("irq_host", 32'(irq_host), 32'(e_ih));
    check_eq("irq_core", 32'(irq_core), 32'(e_ic));
    hrd = wbs_dat_r;
    crd = io_din;
    $display("txn %0d rst=%0b stb=%0b we=%0b adr=%0d wd=%08h ack=%0b dat_r=%08h | rd=%0b wr=%0b ia=%0d iw=%08h din=%08h | irq h=%0b c=%0b",
             txn, r, stb, we, adr, wd, wbs_ack, wbs_dat_r, rd, wr, ia, iw, io_din, irq_host, irq_core);
    txn++;
  endtask

  task automatic idle();
    logic [31:0] a, b;
    cycle(0, 0, 0, 4'd0, 32'h0, 0, 0, 2'd0, 32'h0, a, b);
  endtask

  task automatic hwrite(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] x, y;
    cycle(0, 1, 1, a, d, 0, 0, 2'd0, 32'h0, x, y);
  endtask

  task automatic hread(input logic [3:0] a, output logic [31:0] d);
    logic [31:0] y;
    cycle(0, 1, 0, a, 32'h0, 0, 0, 2'd0, 32'h0, d, y);
  endtask

  task automatic cwrite(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] x, y;
    cycle(0, 0, 0, 4'd0, 32'h0, 0, 1, a, d, x, y);
  endtask

  task automatic cread(input logic [1:0] a, output logic [31:0] d);
    logic [31:0] x;
    cycle(0, 0, 0, 4'd0, 32'h0, 1, 0, a, 32'h0, x, d);
  endtask

  initial begin
    rst = 1; wbs_cyc = 0; wbs_stb = 0; wbs_we = 0; wbs_adr = 0; wbs_dat_w = 0;
    wbs_sel = 0; io_rd = 0; io_wr = 0; io_addr = 0; io_dout = 0;
    en_m = 0;

    // Reset state
    repeat (2) cycle(1, 0, 0, 4'd0, 32'h0, 1, 0, 2'd2, 32'h0, hv, cv);
    hread(4'd2, v);
    check_eq("status_after_reset", v, 32'h0);

    // H2C push three, pop three, then underflow
    repeat (3) hwrite(4'd3, 32'hA5);
    hread(4'd2, v);
    check_eq("h2c_count_3", v, 32'h3);
    repeat (3) begin
      cread(2'd0, v);
      check_eq("h2c_pop_a5", v, 32'hA5);
    end
    hread(4'd2, v);
    check_eq("h2c_count_0", v, 32'h0);
    cread(2'd0, v);
    check_eq("h2c_underflow_data", v, 32'h0);
    cread(2'd3, v);
    check_eq("core_h2c_unf_bit", 32'(v[3]), 32'h1);
    cwrite(2'd3, 32'h8);

    // C2H overflow with DEPTH+1 pushes, then in-order drain
    for (int i = 1; i <= DEPTH + 1; i++) cwrite(2'd1, 32'(i));
    hread(4'd2, v);
    check_eq("c2h_count_full", v, 32'(DEPTH) << 16);
    cread(2'd3, v);
    check_eq("core_c2h_ovf_bit", 32'(v[2]), 32'h1);
    hread(4'd0, v);
    check_eq("host_h2c_ovf_clear", 32'(v[2]), 32'h0);
    for (int i = 1; i <= DEPTH; i++) begin
      hread(4'd4, v);
      check_eq("c2h_order", v, 32'(i));
    end
    cwrite(2'd3, 32'hF);

    // Host interrupt on C2H not-empty
    hwrite(4'd1, 32'h1);
    cwrite(2'd1, 32'h55);
    idle();
    check_eq("irq_host_rise", 32'(irq_host), 32'h1);
    hread(4'd4, v);
    check_eq("c2h_pop_55", v, 32'h55);
    idle();
    check_eq("irq_host_fall", 32'(irq_host), 32'h0);
    hwrite(4'd1, 32'h0);

    // Same-cycle push and pop at count 4
    for (int i = 0; i < 4; i++) hwrite(4'd3, 32'h10 + 32'(i));
    cycle(0, 1, 1, 4'd3, 32'h77, 1, 0, 2'd0, 32'h0, hv, cv);
    check_eq("same_cycle_oldest", cv, 32'h10);
    hread(4'd2, v);
    check_eq("same_cycle_count", v, 32'h4);
    for (int i = 0; i < 4; i++) cread(2'd0, v);
    check_eq("same_cycle_last", v, 32'h77);

    // Flush both FIFOs with a concurrent core push
    hwrite(4'd3, 32'hAA);
    cwrite(2'd1, 32'hBB);
    cycle(0, 1, 1, 4'd5, 32'h3, 0, 1, 2'd1, 32'hCC, hv, cv);
    hread(4'd2, v);
    check_eq("flush_counts", v, 32'h0);
    hread(4'd5, v);
    check_eq("ctrl_reads_0", v, 32'h0);

    // Reset with a strobe in flight, then resume from empty
    cwrite(2'd1, 32'h1);
    hwrite(4'd3, 32'h2);
    cycle(1, 1, 0, 4'd2, 32'h0, 0, 0, 2'd0, 32'h0, hv, cv);
    check_eq("rst_irqs", 32'({irq_host, irq_core}), 32'h0);
    hread(4'd2, v);
    check_eq("rst_counts", v, 32'h0);
    hwrite(4'd3, 32'h99);
    cread(2'd0, v);
    check_eq("post_rst_pop", v, 32'h99);

    // Biased random traffic: fill, drain, balanced
    for (int ph = 0; ph < 3; ph++) begin
      for (int n = 0; n < 500; n++) begin
        int pp, pq, rh, rc;
        bit stb, we, rd, wr;
        logic [3:0] adr;
        logic [1:0] ia;
        logic [31:0] wd, iw;
        pp = (ph == 0) ? 60 : (ph == 1) ? 10 : 35;
        pq = (ph == 0) ? 10 : (ph == 1) ? 60 : 35;
        stb = 0; we = 0; adr = 0; rd = 0; wr = 0; ia = 0;
        wd = $urandom; iw = $urandom;
        rh = $urandom_range(99);
        if (rh < pp) begin stb = 1; we = 1; adr = 4'd3; end
        else if (rh < pp + pq) begin stb = 1; we = 0; adr = 4'd4; end
        else if (rh < pp + pq + 15) begin
          stb = 1; we = 1'($urandom_range(1)); adr = 4'($urandom_range(7));
          if (adr == 4'd5 && $urandom_range(3) != 0) wd = 0;
        end
        rc = $urandom_range(99);
        if (rc < pp) begin wr = 1; ia = 2'd1; end
        else if (rc < pp + pq) begin rd = 1; ia = 2'd0; end
        else if (rc < pp + pq + 15) begin
          ia = 2'($urandom_range(3)); rd = 1'($urandom_range(1)); wr = 1'($urandom_range(1));
        end
        cycle(0, stb, we, adr, wd, rd, wr, ia, iw, hv, cv);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
